traffic_phase_controller: RTL and testbench
===========================================

Name: traffic_phase_controller

Overview:
- Phase sequencer for the two-road intersection; the initiator side of the countdown-timer handshake.
- Issues one-cycle start_timer pulses with a 4-bit seconds value, consumes expired, and uses two_hz_enable only for night-mode flashing.
- Drives main-road, side-road and pedestrian lamps.
- Latches side-road sensor and walk-button requests between phases.

Parameters:
- T_MAIN_GREEN, 6, minimum main green seconds (1..15)
- T_SIDE_GREEN, 4, side green seconds (1..15)
- T_YELLOW, 2, yellow seconds, both roads (1..15)
- T_ALL_RED, 1, all-red clearance seconds (1..15)
- T_WALK, 5, pedestrian walk seconds (1..15)
- T_NIGHT, 15, night-mode timer reload (1..15)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- expired  in  1  timer countdown finished
- two_hz_enable  in  1  timer half-second pulse
- side_sensor  in  1  vehicle waiting on side road, level
- walk_req  in  1  pedestrian button, level/pulse
- night_mode  in  1  flashing-operation request, level
- start_timer  out  1  one-cycle timer load strobe
- value  out  4  seconds loaded with start_timer
- main_light  out  3  {red,yellow,green}, one-hot or 000
- side_light  out  3  {red,yellow,green}, one-hot or 000
- walk_light  out  1  pedestrian walk lamp
- state_dbg  out  3  current state encoding

Behaviour:
- All outputs are registered.
- States: MAIN_GREEN=0, MAIN_YELLOW=1, ALL_RED_A=2, WALK=3, SIDE_GREEN=4, SIDE_YELLOW=5, ALL_RED_B=6, NIGHT=7.
- Reset values: state=ALL_RED_B, start_timer=0, value=0, main_light=side_light=100, walk_light=0, pending flags=0, flash=0, boot=1.
- Boot: at the first non-reset edge with boot=1, assert start_timer=1 and value=T_ALL_RED, then clear boot. The state stays ALL_RED_B.
- Start rule: every state entry asserts start_timer=1 for exactly one cycle, with value=T(new state), on the same edge as the state change.
- Expiry acceptance: expired is accepted only in a cycle where start_timer=0 and boot=0. The stale expired=1 seen during the start cycle is ignored.
- Transitions on an accepted expiry. night_mode=1 has priority: go to NIGHT, clear both pending flags, flash=0.
  - MAIN_GREEN: if side_pend or walk_pend, go to MAIN_YELLOW. Otherwise hold without restarting the timer; re-evaluate every cycle while expired=1.
  - MAIN_YELLOW → ALL_RED_A.
  - ALL_RED_A → WALK if walk_pend, else SIDE_GREEN.
  - WALK → SIDE_GREEN if side_pend, else ALL_RED_B.
  - SIDE_GREEN → SIDE_YELLOW → ALL_RED_B → MAIN_GREEN.
  - NIGHT: restart with value=T_NIGHT and stay in NIGHT.
- NIGHT exit: night_mode=0 in any non-start cycle goes to ALL_RED_B (start with T_ALL_RED) immediately, without waiting for expiry.
- Request latching:
  - side_sensor=1 sets side_pend; walk_req=1 sets walk_pend.
  - Entry to SIDE_GREEN clears side_pend; entry to WALK clears walk_pend.
  - If set and clear fall on the same edge, set wins.
  - Requests are ignored while in NIGHT.
- Lamps:
  - MAIN_GREEN: main 001, side 100.
  - MAIN_YELLOW: main 010, side 100.
  - ALL_RED_A, ALL_RED_B: main 100, side 100.
  - WALK: main 100, side 100, walk_light=1.
  - SIDE_GREEN: main 100, side 001.
  - SIDE_YELLOW: main 100, side 010.
  - NIGHT: flash toggles on each two_hz_enable=1; main = flash?010:000, side = flash?100:000.
  - walk_light=0 in every state except WALK.
- Mid-operation reset: synchronous reset in any state returns all registers to reset values on that edge. The boot start follows at the next non-reset edge.
- Width rule: value is exactly the 4-bit parameter. A parameter of 0 or above 15 is illegal and must be caught by an elaboration-time check (reject or clamp to 1).

Decomposition:
- Shared package holds:
  - state encoding constants (3-bit)
  - lamp encodings RED=100, YEL=010, GRN=001, OFF=000
  - default phase-time constants
- Sub-module: phase_request_latch, holding side_pend and walk_pend with set-wins-over-clear semantics.
- The FSM, start strobe and lamp decode stay in the top module.

Test Plan:
- The bench uses a behavioural timer with one count per N cycles, matching the handshake: expired cleared on the start edge, one_hz and two_hz pulses.
- Reset then release → start_timer=1 with value=1 on the first edge; after expiry, state 6→0; start_timer=1 with value=6; main_light=001.
- No requests with MAIN_GREEN expired → state holds at 0 and no further start_timer pulses. A one-cycle side_sensor pulse then gives next edge MAIN_YELLOW with value=2, then ALL_RED_A (1), SIDE_GREEN (4), SIDE_YELLOW (2), ALL_RED_B (1), MAIN_GREEN (6).
- walk_req and side_sensor both latched in MAIN_GREEN → sequence 0→1→2→3→4→5→6→0; walk_light=1 only in state 3; both pending flags end at 0.
- Stale-expired check: the timer model holds expired=1 during the start cycle → FSM does not advance and exactly one start pulse is issued per state.
- night_mode=1 during SIDE_GREEN → NIGHT at that expiry with value=15; main_light toggles 000/010 on each two_hz pulse. night_mode=0 → next edge ALL_RED_B with value=1, then MAIN_GREEN.
- Reset asserted mid-WALK → lamps all red, walk_light=0, pending flags 0, start_timer=0; boot start is issued after release.

Source files
------------

// File: rtl/traffic_phase_controller_pkg.sv
// Shared encodings and default phase times for the two-road intersection sequencer.
package traffic_phase_controller_pkg;

  localparam logic [2:0] S_MAIN_GREEN  = 3'd0;
  localparam logic [2:0] S_MAIN_YELLOW = 3'd1;
  localparam logic [2:0] S_ALL_RED_A   = 3'd2;
  localparam logic [2:0] S_WALK        = 3'd3;
  localparam logic [2:0] S_SIDE_GREEN  = 3'd4;
  localparam logic [2:0] S_SIDE_YELLOW = 3'd5;
  localparam logic [2:0] S_ALL_RED_B   = 3'd6;
  localparam logic [2:0] S_NIGHT       = 3'd7;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  localparam int DEF_T_MAIN_GREEN = 6;
  localparam int DEF_T_SIDE_GREEN = 4;
  localparam int DEF_T_YELLOW     = 2;
  localparam int DEF_T_ALL_RED    = 1;
  localparam int DEF_T_WALK       = 5;
  localparam int DEF_T_NIGHT      = 15;

  // Out-of-range phase times are clamped to 1 s so the timer load always fits 4 bits.
  function automatic logic [3:0] phase_time(input int t);
    if (t < 1 || t > 15) return 4'd1;
    return t[3:0];
  endfunction

endpackage

// File: rtl/traffic_phase_controller_request_latch.sv
// Side-road and pedestrian request flags; a set on the same edge as a clear wins.
module phase_request_latch (
  input  logic clock,
  input  logic reset,
  input  logic side_set,
  input  logic side_clr,
  input  logic walk_set,
  input  logic walk_clr,
  input  logic flush,
  output logic side_pend,
  output logic walk_pend
);

  // flush (night entry) drops every outstanding request, even one arriving that cycle.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      side_pend <= 1'b0;
      walk_pend <= 1'b0;
    end else begin
      side_pend <= side_set | (side_pend & ~side_clr);
      walk_pend <= walk_set | (walk_pend & ~walk_clr);
    end
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// Intersection phase sequencer: starts the countdown timer on every phase entry
// and advances on accepted expiry; drives registered lamp outputs.
//
// state         | meaning
// MAIN_GREEN    | main road green, held until a request is pending
// MAIN_YELLOW   | main road yellow
// ALL_RED_A     | clearance before walk / side green
// WALK          | pedestrian walk lamp, all vehicles red
// SIDE_GREEN    | side road green
// SIDE_YELLOW   | side road yellow
// ALL_RED_B     | clearance before main green; also reset / boot state
// NIGHT         | flashing yellow main / red side
module traffic_phase_controller
  import traffic_phase_controller_pkg::*;
#(
  parameter int T_MAIN_GREEN = DEF_T_MAIN_GREEN,
  parameter int T_SIDE_GREEN = DEF_T_SIDE_GREEN,
  parameter int T_YELLOW     = DEF_T_YELLOW,
  parameter int T_ALL_RED    = DEF_T_ALL_RED,
  parameter int T_WALK       = DEF_T_WALK,
  parameter int T_NIGHT      = DEF_T_NIGHT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       expired,
  input  logic       two_hz_enable,
  input  logic       side_sensor,
  input  logic       walk_req,
  input  logic       night_mode,
  output logic       start_timer,
  output logic [3:0] value,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk_light,
  output logic [2:0] state_dbg
);

  localparam logic [3:0] TV_MAIN_GREEN = phase_time(T_MAIN_GREEN);
  localparam logic [3:0] TV_SIDE_GREEN = phase_time(T_SIDE_GREEN);
  localparam logic [3:0] TV_YELLOW     = phase_time(T_YELLOW);
  localparam logic [3:0] TV_ALL_RED    = phase_time(T_ALL_RED);
  localparam logic [3:0] TV_WALK       = phase_time(T_WALK);
  localparam logic [3:0] TV_NIGHT      = phase_time(T_NIGHT);

  logic [2:0] state;
  logic [2:0] nxt_state;
  logic       boot;
  logic       flash;
  logic       nxt_flash;
  logic       do_start;
  logic       flush;
  logic       accept;
  logic       side_pend;
  logic       walk_pend;
  logic [3:0] nxt_value;
  logic [2:0] nxt_main;
  logic [2:0] nxt_side;

  phase_request_latch u_req (
    .clock     (clock),
    .reset     (reset),
    .side_set  (side_sensor && (state != S_NIGHT)),
    .side_clr  (do_start && (nxt_state == S_SIDE_GREEN)),
    .walk_set  (walk_req && (state != S_NIGHT)),
    .walk_clr  (do_start && (nxt_state == S_WALK)),
    .flush     (flush),
    .side_pend (side_pend),
    .walk_pend (walk_pend)
  );

  // expired still reads 1 during the start cycle (timer has not reloaded yet), so it is masked.
  always_comb begin
    accept    = expired && !start_timer && !boot;
    nxt_state = state;
    do_start  = 1'b0;
    flush     = 1'b0;
    if (boot) begin
      do_start = 1'b1;
    end else if (state == S_NIGHT) begin
      if (!start_timer && !night_mode) begin
        nxt_state = S_ALL_RED_B;
        do_start  = 1'b1;
      end else if (accept) begin
        do_start = 1'b1;
      end
    end else if (accept) begin
      if (night_mode) begin
        nxt_state = S_NIGHT;
        flush     = 1'b1;
      end else begin
        case (state)
          S_MAIN_GREEN:  if (side_pend || walk_pend) nxt_state = S_MAIN_YELLOW;
          S_MAIN_YELLOW: nxt_state = S_ALL_RED_A;
          S_ALL_RED_A:   nxt_state = walk_pend ? S_WALK : S_SIDE_GREEN;
          S_WALK:        nxt_state = side_pend ? S_SIDE_GREEN : S_ALL_RED_B;
          S_SIDE_GREEN:  nxt_state = S_SIDE_YELLOW;
          S_SIDE_YELLOW: nxt_state = S_ALL_RED_B;
          S_ALL_RED_B:   nxt_state = S_MAIN_GREEN;
          default:       nxt_state = state;
        endcase
      end
      do_start = (nxt_state != state);
    end
  end

  always_comb begin
    nxt_flash = flash;
    if (flush) nxt_flash = 1'b0;
    else if (state == S_NIGHT && nxt_state == S_NIGHT && two_hz_enable) nxt_flash = ~flash;
  end

  always_comb begin
    nxt_value = TV_ALL_RED;
    case (nxt_state)
      S_MAIN_GREEN:  nxt_value = TV_MAIN_GREEN;
      S_MAIN_YELLOW: nxt_value = TV_YELLOW;
      S_WALK:        nxt_value = TV_WALK;
      S_SIDE_GREEN:  nxt_value = TV_SIDE_GREEN;
      S_SIDE_YELLOW: nxt_value = TV_YELLOW;
      S_NIGHT:       nxt_value = TV_NIGHT;
      default:       nxt_value = TV_ALL_RED;
    endcase
  end

  always_comb begin
    nxt_main = LAMP_RED;
    nxt_side = LAMP_RED;
    case (nxt_state)
      S_MAIN_GREEN:  nxt_main = LAMP_GRN;
      S_MAIN_YELLOW: nxt_main = LAMP_YEL;
      S_SIDE_GREEN:  nxt_side = LAMP_GRN;
      S_SIDE_YELLOW: nxt_side = LAMP_YEL;
      S_NIGHT: begin
        nxt_main = nxt_flash ? LAMP_YEL : LAMP_OFF;
        nxt_side = nxt_flash ? LAMP_RED : LAMP_OFF;
      end
      default: begin
        nxt_main = LAMP_RED;
        nxt_side = LAMP_RED;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_ALL_RED_B;
      start_timer <= 1'b0;
      value       <= 4'd0;
      main_light  <= LAMP_RED;
      side_light  <= LAMP_RED;
      walk_light  <= 1'b0;
      flash       <= 1'b0;
      boot        <= 1'b1;
    end else begin
      state       <= nxt_state;
      start_timer <= do_start;
      if (do_start) value <= nxt_value;
      main_light  <= nxt_main;
      side_light  <= nxt_side;
      walk_light  <= (nxt_state == S_WALK);
      flash       <= nxt_flash;
      boot        <= 1'b0;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Self-checking bench: behavioural countdown timer plus a rule-level reference model.
module tb_traffic_phase_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       expired;
  logic       two_hz_enable;
  logic       side_sensor = 1'b0;
  logic       walk_req = 1'b0;
  logic       night_mode = 1'b0;
  logic       start_timer;
  logic [3:0] value;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk_light;
  logic [2:0] state_dbg;

  int total = 0;
  int passed = 0;

  traffic_phase_controller dut (
    .clock         (clock),
    .reset         (reset),
    .expired       (expired),
    .two_hz_enable (two_hz_enable),
    .side_sensor   (side_sensor),
    .walk_req      (walk_req),
    .night_mode    (night_mode),
    .start_timer   (start_timer),
    .value         (value),
    .main_light    (main_light),
    .side_light    (side_light),
    .walk_light    (walk_light),
    .state_dbg     (state_dbg)
  );

  always #5 clock = ~clock;

  // Behavioural timer: 4 cycles per second, expired held until the next load.
  logic [1:0] div = 2'd0;
  logic [3:0] tcnt = 4'd0;
  initial begin
    expired = 1'b0;
    two_hz_enable = 1'b0;
  end
  always @(posedge clock) begin
    if (reset) begin
      div <= 2'd0; tcnt <= 4'd0; expired <= 1'b0; two_hz_enable <= 1'b0;
    end else begin
      div <= div + 2'd1;
      two_hz_enable <= (div == 2'd1) || (div == 2'd3);
      if (start_timer) begin
        tcnt <= value; expired <= 1'b0;
      end else if (!expired && div == 2'd3 && tcnt != 4'd0) begin
        tcnt <= tcnt - 4'd1;
        if (tcnt == 4'd1) expired <= 1'b1;
      end
    end
  end

  // Reference model: phase numbers 0..7 with durations and lamp tables.
  int dur [8] = '{6, 2, 1, 5, 4, 2, 1, 15};
  logic [2:0] main_tab [8] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
  logic [2:0] side_tab [8] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000};
  logic [2:0] m_state = 3'd6;
  logic       m_start = 1'b0, m_boot = 1'b1, m_side = 1'b0, m_walk = 1'b0, m_flash = 1'b0;
  logic [3:0] m_value = 4'd0;
  int ns;
  bit st, ok, sp, wp, fl;

  always @(posedge clock) begin
    if (reset) begin
      m_state <= 3'd6; m_start <= 1'b0; m_value <= 4'd0; m_boot <= 1'b1;
      m_side <= 1'b0; m_walk <= 1'b0; m_flash <= 1'b0;
    end else begin
      ns = int'(m_state); st = 1'b0;
      ok = expired && !m_start && !m_boot;
      if (m_boot) st = 1'b1;
      else if (m_state == 3'd7) begin
        if (!m_start && !night_mode) begin ns = 6; st = 1'b1; end
        else if (ok) st = 1'b1;
      end else if (ok) begin
        if (night_mode) ns = 7;
        else case (m_state)
          3'd0: ns = (m_side || m_walk) ? 1 : 0;
          3'd2: ns = m_walk ? 3 : 4;
          3'd3: ns = m_side ? 4 : 6;
          3'd6: ns = 0;
          default: ns = int'(m_state) + 1;
        endcase
        st = (ns != int'(m_state));
      end
      sp = m_side && !(st && ns == 4);
      wp = m_walk && !(st && ns == 3);
      if (m_state != 3'd7) begin sp = sp || side_sensor; wp = wp || walk_req; end
      if (ns == 7 && m_state != 3'd7) begin sp = 1'b0; wp = 1'b0; end
      if (ns == 7 && m_state != 3'd7) fl = 1'b0;
      else if (ns == 7 && two_hz_enable) fl = !m_flash;
      else fl = m_flash;
      m_state <= 3'(ns);
      m_start <= st;
      if (st) m_value <= 4'(dur[ns]);
      m_side <= sp; m_walk <= wp; m_flash <= fl; m_boot <= 1'b0;
    end
  end

  function automatic logic [14:0] dut_vec();
    return {state_dbg, start_timer, (start_timer ? value : 4'h0), main_light, side_light, walk_light};
  endfunction

  function automatic logic [14:0] ref_vec();
    logic [2:0] mm, ss;
    mm = (m_state == 3'd7) ? (m_flash ? 3'b010 : 3'b000) : main_tab[m_state];
    ss = (m_state == 3'd7) ? (m_flash ? 3'b100 : 3'b000) : side_tab[m_state];
    return {m_state, m_start, (m_start ? m_value : 4'h0), mm, ss, (m_state == 3'd3)};
  endfunction

  task automatic clk1();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) clk1();
    total++;
    if ({state_dbg, start_timer, value, main_light, side_light, walk_light} !== {3'd6, 1'b0, 4'd0, 3'b100, 3'b100, 1'b0})
      $display("FAIL reset_outputs: got %h expected %h", {state_dbg, start_timer, value, main_light, side_light, walk_light},
               {3'd6, 1'b0, 4'd0, 3'b100, 3'b100, 1'b0});
    else passed++;
    total++;
    if ({dut.u_req.side_pend, dut.u_req.walk_pend} !== 2'b00)
      $display("FAIL reset_pending: got %b expected 00", {dut.u_req.side_pend, dut.u_req.walk_pend});
    else passed++;
  endtask

  task automatic test_boot();
    bit done = 0;
    reset = 1'b0;
    clk1();
    total++;
    if ({state_dbg, start_timer, value} !== {3'd6, 1'b1, 4'd1})
      $display("FAIL boot_start: got %h expected %h", {state_dbg, start_timer, value}, {3'd6, 1'b1, 4'd1});
    else passed++;
    for (int i = 0; i < 40 && !done; i++) begin
      clk1();
      total++;
      if (dut_vec() !== ref_vec()) $display("FAIL boot_track cyc %0d: got %h expected %h", i, dut_vec(), ref_vec());
      else passed++;
      if (state_dbg == 3'd0 && start_timer) done = 1;
    end
    total++;
    if ({done, start_timer, value, main_light} !== {1'b1, 1'b1, 4'd6, 3'b001})
      $display("FAIL boot_main_green: got %h expected %h", {done, start_timer, value, main_light}, {1'b1, 1'b1, 4'd6, 3'b001});
    else passed++;
  endtask

  task automatic test_hold_no_request();
    bit reached = 0;
    int starts = 0;
    for (int i = 0; i < 80 && !reached; i++) begin
      clk1();
      total++;
      if (dut_vec() !== ref_vec()) $display("FAIL hold_track cyc %0d: got %h expected %h", i, dut_vec(), ref_vec());
      else passed++;
      if (state_dbg == 3'd0 && expired) reached = 1;
    end
    total++;
    if (!reached) $display("FAIL hold_reach: got 0 expected 1");
    else passed++;
    repeat (12) begin
      clk1();
      if (start_timer) starts++;
    end
    total++;
    if ({state_dbg, 8'(starts)} !== {3'd0, 8'd0})
      $display("FAIL hold_idle: got state %0d starts %0d expected state 0 starts 0", state_dbg, starts);
    else passed++;
  endtask

  task automatic test_side_only();
    logic [63:0] seq = '0;
    bit done = 0;
    side_sensor = 1'b1; clk1(); side_sensor = 1'b0;
    for (int i = 0; i < 120 && !done; i++) begin
      clk1();
      total++;
      if (dut_vec() !== ref_vec()) $display("FAIL side_track cyc %0d: got %h expected %h", i, dut_vec(), ref_vec());
      else passed++;
      if (start_timer) begin
        seq = (seq << 8) | {56'd0, 1'b0, state_dbg, value};
        if (state_dbg == 3'd0) done = 1;
      end
    end
    total++;
    if (seq !== 64'h0000_1221_4452_6106)
      $display("FAIL side_sequence: got %h expected %h", seq, 64'h0000_1221_4452_6106);
    else passed++;
  endtask

  task automatic test_walk_and_side();
    logic [63:0] seq = '0;
    bit done = 0, reached = 0;
    int walk_bad = 0, walk_seen = 0;
    for (int i = 0; i < 80 && !reached; i++) begin
      clk1();
      if (state_dbg == 3'd0 && expired) reached = 1;
    end
    walk_req = 1'b1; side_sensor = 1'b1; clk1(); walk_req = 1'b0; side_sensor = 1'b0;
    for (int i = 0; i < 150 && !done; i++) begin
      clk1();
      total++;
      if (dut_vec() !== ref_vec()) $display("FAIL walk_track cyc %0d: got %h expected %h", i, dut_vec(), ref_vec());
      else passed++;
      if (walk_light !== (state_dbg == 3'd3)) walk_bad++;
      if (walk_light) walk_seen++;
      if (start_timer) begin
        seq = (seq << 8) | {56'd0, 1'b0, state_dbg, value};
        if (state_dbg == 3'd0) done = 1;
      end
    end
    total++;
    if (seq !== 64'h0012_2135_4452_6106)
      $display("FAIL walk_sequence: got %h expected %h", seq, 64'h0012_2135_4452_6106);
    else passed++;
    total++;
    if (walk_bad != 0 || walk_seen == 0)
      $display("FAIL walk_lamp: got bad %0d seen %0d expected bad 0 seen >0", walk_bad, walk_seen);
    else passed++;
    total++;
    if ({dut.u_req.side_pend, dut.u_req.walk_pend} !== 2'b00)
      $display("FAIL walk_pending_clear: got %b expected 00", {dut.u_req.side_pend, dut.u_req.walk_pend});
    else passed++;
  endtask

  task automatic test_night();
    bit done = 0;
    logic [2:0] prev = 3'd0;
    int toggles = 0, bad = 0, restarts = 0;
    logic [2:0] last_main;
    side_sensor = 1'b1; clk1(); side_sensor = 1'b0;
    for (int i = 0; i < 150 && !done; i++) begin
      clk1();
      if (state_dbg == 3'd4 && start_timer) done = 1;
    end
    night_mode = 1'b1;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      prev = state_dbg;
      clk1();
      if (state_dbg == 3'd7 && start_timer) done = 1;
    end
    total++;
    if ({done, prev, state_dbg, value} !== {1'b1, 3'd4, 3'd7, 4'd15})
      $display("FAIL night_entry: got %h expected %h", {done, prev, state_dbg, value}, {1'b1, 3'd4, 3'd7, 4'd15});
    else passed++;
    last_main = main_light;
    for (int i = 0; i < 75; i++) begin
      clk1();
      total++;
      if (dut_vec() !== ref_vec()) $display("FAIL night_track cyc %0d: got %h expected %h", i, dut_vec(), ref_vec());
      else passed++;
      if (main_light != last_main) toggles++;
      if (!(main_light inside {3'b000, 3'b010}) || !(side_light inside {3'b000, 3'b100})) bad++;
      if (start_timer && state_dbg == 3'd7 && value == 4'd15) restarts++;
      last_main = main_light;
    end
    total++;
    if (bad != 0 || toggles < 20 || restarts < 1)
      $display("FAIL night_flash: got bad %0d toggles %0d restarts %0d expected 0 >=20 >=1", bad, toggles, restarts);
    else passed++;
    if (start_timer) clk1();
    night_mode = 1'b0;
    clk1();
    total++;
    if ({state_dbg, start_timer, value} !== {3'd6, 1'b1, 4'd1})
      $display("FAIL night_exit: got %h expected %h", {state_dbg, start_timer, value}, {3'd6, 1'b1, 4'd1});
    else passed++;
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      clk1();
      if (state_dbg == 3'd0 && start_timer) done = 1;
    end
    total++;
    if ({done, value, main_light} !== {1'b1, 4'd6, 3'b001})
      $display("FAIL night_to_main: got %h expected %h", {done, value, main_light}, {1'b1, 4'd6, 3'b001});
    else passed++;
  endtask

  task automatic test_reset_mid_walk();
    bit done = 0;
    walk_req = 1'b1; clk1(); walk_req = 1'b0;
    for (int i = 0; i < 150 && !done; i++) begin
      clk1();
      if (state_dbg == 3'd3) done = 1;
    end
    total++;
    if (!done) $display("FAIL midwalk_reach: got state %0d expected 3", state_dbg);
    else passed++;
    side_sensor = 1'b1; clk1(); side_sensor = 1'b0;
    reset = 1'b1; clk1();
    total++;
    if ({state_dbg, start_timer, main_light, side_light, walk_light, dut.u_req.side_pend, dut.u_req.walk_pend}
        !== {3'd6, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00})
      $display("FAIL midwalk_reset: got %h expected %h",
               {state_dbg, start_timer, main_light, side_light, walk_light, dut.u_req.side_pend, dut.u_req.walk_pend},
               {3'd6, 1'b0, 3'b100, 3'b100, 1'b0, 2'b00});
    else passed++;
    reset = 1'b0; clk1();
    total++;
    if ({state_dbg, start_timer, value} !== {3'd6, 1'b1, 4'd1})
      $display("FAIL midwalk_boot: got %h expected %h", {state_dbg, start_timer, value}, {3'd6, 1'b1, 4'd1});
    else passed++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 3000; i++) begin
      side_sensor = ($urandom_range(15) == 0);
      walk_req    = ($urandom_range(19) == 0);
      if ($urandom_range(199) == 0) night_mode = ~night_mode;
      reset       = ($urandom_range(499) == 0);
      clk1();
      total++;
      if (dut_vec() !== ref_vec()) begin
        errs++;
        if (errs <= 10) $display("FAIL random_track cyc %0d: got %h expected %h", i, dut_vec(), ref_vec());
      end else passed++;
    end
    side_sensor = 1'b0; walk_req = 1'b0; night_mode = 1'b0; reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_boot();
    test_hold_no_request();
    test_side_only();
    test_walk_and_side();
    test_night();
    test_reset_mid_walk();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
